e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage; companion to the combinational ALU.
- Holds the HI/LO registers, computes signed/unsigned multiply and divide with configurable latency, and raises a busy/stall indication so the hazard unit can freeze the pipeline.
- MTHI/MTLO writes and MFHI/MFLO reads also go through this block.

Parameters:
- WIDTH, 32, operand, HI and LO width in bits (>=8).
- MULT_CYCLES, 5, busy cycles for a multiply (>=1).
- DIV_CYCLES, 10, busy cycles for a divide (>=1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- E_MDUA  input  WIDTH  operand A (rs).
- E_MDUB  input  WIDTH  operand B (rt).
- E_MDUOp  input  3  operation: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
- E_Start  input  1  qualifies E_MDUOp this cycle.
- E_MDUSel  input  1  read select: 0 LO, 1 HI.
- E_MDURe  output  WIDTH  combinational read of the selected register.
- E_Busy  output  1  operation in progress.
- E_MDUStall  output  1  combinational: E_Busy | (E_Start & op in MULT..DIVU).
- E_HI, E_LO  output  WIDTH  architectural HI and LO.

Behaviour:
- Reset (clk edge with reset=1): HI=0, LO=0, E_Busy=0, counter=0, shadow results cleared. Any in-flight operation is discarded and HI/LO are not updated. Reset dominates E_Start in the same cycle.
- Clock-enable rule: E_Start is accepted only when E_Busy=0. E_Start during busy is ignored entirely: no MTHI/MTLO write, no restart.
- MULT/MULTU accepted at edge T0:
  - The full 2*WIDTH product of the operands as sampled at T0 is latched into shadow hi/lo.
  - counter = MULT_CYCLES; E_Busy=1 from T0 until the edge ending the last busy cycle.
  - At that edge HI/LO take the shadow values and E_Busy=0. New values are visible MULT_CYCLES cycles after T0.
- DIV/DIVU: same sequencing with DIV_CYCLES.
  - LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case (most negative value / -1): LO = most negative value, HI = 0.
  - Divide by zero (B=0): the operation still occupies DIV_CYCLES busy cycles, but HI/LO keep their prior values at completion.
- Operands are sampled only at acceptance. Later changes on E_MDUA/E_MDUB do not affect the result.
- MTHI/MTLO accepted at edge T0: HI (or LO) = E_MDUA at that edge. E_Busy is not asserted. No latency beyond one edge.
- Counter decrements once per cycle while busy. E_Busy falls at the edge where the counter goes 1 -> 0. Counter never wraps below 0.
- E_MDURe reflects architectural HI/LO only; shadow values are never visible. While busy it returns the pre-operation values. The hazard unit is responsible for stalling MFHI/MFLO via E_MDUStall.
- Back-to-back operations: a new E_Start is accepted in the cycle immediately after E_Busy falls. That gives zero bubble beyond the busy window.
- op none/reserved with E_Start=1: no state change.
- All arithmetic is modulo WIDTH per half. Signed ops interpret operands as two's complement.

Test Plan:
- Reset, then MULTU A=0xFFFFFFFF B=0x2 -> E_Busy high for 5 cycles; then HI=0x00000001, LO=0xFFFFFFFE; E_MDUSel=1 reads 0x00000001.
- MULT A=0xFFFFFFFD (-3) B=0x7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB after 5 cycles. Change A mid-busy to 0x1 -> result unchanged.
- DIV A=0xFFFFFFF9 (-7) B=0x2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands -> LO=0x7FFFFFFC, HI=0x1.
- MTLO 0x12345678, then DIVU A=5 B=0 -> 10 busy cycles; LO stays 0x12345678 and HI stays its prior value. Separately, DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- During a busy DIV, pulse E_Start with MTHI A=0xAAAA -> ignored: E_MDUStall=1 throughout and HI changes only by the divide result. Issue MULT in the first cycle after E_Busy falls -> accepted.
- Start DIV, assert reset at busy cycle 4 -> next cycle E_Busy=0, HI=LO=0, and no late commit happens in the following 10 cycles.

Source files
------------

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu
// Purpose  : EX-stage multi-cycle multiply/divide unit owning HI/LO, with
//            busy/stall outputs for the hazard unit.
// Revision : 1.0  initial release
// ============================================================================
module e_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_MDUA,
  input  logic [WIDTH-1:0] E_MDUB,
  input  logic [2:0]       E_MDUOp,
  input  logic             E_Start,
  input  logic             E_MDUSel,
  output logic [WIDTH-1:0] E_MDURe,
  output logic             E_Busy,
  output logic             E_MDUStall,
  output logic [WIDTH-1:0] E_HI,
  output logic [WIDTH-1:0] E_LO
);

  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] c_MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic             sh_wr_q, sh_wr_d;

  logic             w_accept;
  logic             w_is_arith;
  logic             w_signed;
  logic [2*WIDTH-1:0] w_mul_a, w_mul_b, w_prod;
  logic             w_a_neg, w_b_neg, w_div_zero;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_den;
  logic [WIDTH-1:0] w_q_mag, w_r_mag, w_quot, w_rem;

  assign w_accept   = E_Start & (state_q == c_ST_IDLE);
  assign w_is_arith = (E_MDUOp >= c_OP_MULT) & (E_MDUOp <= c_OP_DIVU);
  assign w_signed   = (E_MDUOp == c_OP_MULT) | (E_MDUOp == c_OP_DIV);

  // Operands are widened to 2*WIDTH so one unsigned multiply yields the
  // exact low 2*WIDTH bits of both the signed and the unsigned product.
  assign w_mul_a = w_signed ? {{WIDTH{E_MDUA[WIDTH-1]}}, E_MDUA} : {{WIDTH{1'b0}}, E_MDUA};
  assign w_mul_b = w_signed ? {{WIDTH{E_MDUB[WIDTH-1]}}, E_MDUB} : {{WIDTH{1'b0}}, E_MDUB};
  assign w_prod  = w_mul_a * w_mul_b;

  // Sign-magnitude divide; MIN / -1 falls out naturally as MIN rem 0.
  assign w_div_zero = (E_MDUB == '0);
  assign w_a_neg    = w_signed & E_MDUA[WIDTH-1];
  assign w_b_neg    = w_signed & E_MDUB[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -E_MDUA : E_MDUA;
  assign w_b_mag    = w_b_neg ? -E_MDUB : E_MDUB;
  assign w_den      = w_div_zero ? WIDTH'(1) : w_b_mag;
  assign w_q_mag    = w_a_mag / w_den;
  assign w_r_mag    = w_a_mag % w_den;
  assign w_quot     = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_rem      = w_a_neg ? -w_r_mag : w_r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      sh_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_wr_q <= sh_wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: if (w_accept && w_is_arith) state_d = c_ST_BUSY;
      c_ST_BUSY: if (cnt_q <= c_CNT_ONE)     state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_wr_d = sh_wr_q;
    if (state_q == c_ST_BUSY) begin
      if (cnt_q != '0) cnt_d = cnt_q - c_CNT_ONE;
      // Commit on the edge that ends the last busy cycle; divide-by-zero
      // leaves sh_wr_q clear so HI/LO are preserved.
      if ((cnt_q == c_CNT_ONE) && sh_wr_q) begin
        hi_d = sh_hi_q;
        lo_d = sh_lo_q;
      end
    end else if (w_accept) begin
      case (E_MDUOp)
        c_OP_MULT, c_OP_MULTU: begin
          sh_hi_d = w_prod[2*WIDTH-1:WIDTH];
          sh_lo_d = w_prod[WIDTH-1:0];
          sh_wr_d = 1'b1;
          cnt_d   = c_MULT_CNT;
        end
        c_OP_DIV, c_OP_DIVU: begin
          sh_hi_d = w_rem;
          sh_lo_d = w_quot;
          sh_wr_d = ~w_div_zero;
          cnt_d   = c_DIV_CNT;
        end
        c_OP_MTHI: hi_d = E_MDUA;
        c_OP_MTLO: lo_d = E_MDUA;
        default: ;
      endcase
    end
  end

  always_comb begin
    E_Busy     = (state_q == c_ST_BUSY);
    E_MDUStall = E_Busy | (E_Start & w_is_arith);
    E_MDURe    = E_MDUSel ? hi_q : lo_q;
    E_HI       = hi_q;
    E_LO       = lo_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_mdu
// Purpose  : Directed self-checking bench for e_mdu with an expected-result
//            queue drained when each multi-cycle operation completes.
// Revision : 1.0  initial release
// ============================================================================
module tb_e_mdu;

  localparam int c_MULT = 5;
  localparam int c_DIV  = 10;

  localparam logic [2:0] c_NONE  = 3'd0;
  localparam logic [2:0] c_MULTS = 3'd1;
  localparam logic [2:0] c_MULTU = 3'd2;
  localparam logic [2:0] c_DIVS  = 3'd3;
  localparam logic [2:0] c_DIVU  = 3'd4;
  localparam logic [2:0] c_MTHI  = 3'd5;
  localparam logic [2:0] c_MTLO  = 3'd6;
  localparam logic [2:0] c_RSVD  = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_MDUA, E_MDUB, E_MDURe, E_HI, E_LO;
  logic [2:0]  E_MDUOp;
  logic        E_Start, E_MDUSel, E_Busy, E_MDUStall;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_hi, m_lo;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  e_mdu #(.WIDTH(32), .MULT_CYCLES(c_MULT), .DIV_CYCLES(c_DIV), .CNT_W(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .E_MDUA     (E_MDUA),
    .E_MDUB     (E_MDUB),
    .E_MDUOp    (E_MDUOp),
    .E_Start    (E_Start),
    .E_MDUSel   (E_MDUSel),
    .E_MDURe    (E_MDURe),
    .E_Busy     (E_Busy),
    .E_MDUStall (E_MDUStall),
    .E_HI       (E_HI),
    .E_LO       (E_LO)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    E_MDUOp = op;
    E_MDUA  = a;
    E_MDUB  = b;
    E_Start = 1'b1;
    #1;
    if (op >= c_MULTS && op <= c_DIVU) check("stall_on_request", 32'(E_MDUStall), 32'd1);
    tick();
    E_Start = 1'b0;
    E_MDUOp = c_NONE;
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    exp_q.push_back(e);
  endtask

  // Counts remaining busy cycles (bounded), then pops and compares the result.
  task automatic wait_done(input string tag, input int n);
    int   cnt = 0;
    exp_t e;
    check({tag, "_busy_start"}, 32'(E_Busy), 32'd1);
    while (E_Busy === 1'b1 && cnt < 64) begin
      check({tag, "_stall"}, 32'(E_MDUStall), 32'd1);
      check({tag, "_read_old"}, E_MDURe, E_MDUSel ? m_hi : m_lo);
      tick();
      cnt++;
    end
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_hi"}, E_HI, e.hi);
      check({tag, "_lo"}, E_LO, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  initial begin
    reset = 1'b1; E_Start = 1'b0; E_MDUOp = c_NONE; E_MDUA = '0; E_MDUB = '0; E_MDUSel = 1'b0;
    m_hi = '0; m_lo = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_hi", E_HI, 32'h0);
    check("rst_lo", E_LO, 32'h0);
    check("rst_busy", 32'(E_Busy), 32'd0);
    check("rst_stall", 32'(E_MDUStall), 32'd0);

    issue(c_MULTU, 32'hFFFFFFFF, 32'h2);
    push(32'h00000001, 32'hFFFFFFFE);
    wait_done("multu", c_MULT);
    E_MDUSel = 1'b1; #1;
    check("read_hi", E_MDURe, 32'h00000001);
    E_MDUSel = 1'b0; #1;
    check("read_lo", E_MDURe, 32'hFFFFFFFE);

    issue(c_MULTS, 32'hFFFFFFFD, 32'h7);
    push(32'hFFFFFFFF, 32'hFFFFFFEB);
    E_MDUA = 32'h1;
    wait_done("mult_neg", c_MULT);

    issue(c_DIVS, 32'hFFFFFFF9, 32'h2);
    push(32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_done("div_neg", c_DIV);

    issue(c_DIVU, 32'hFFFFFFF9, 32'h2);
    push(32'h00000001, 32'h7FFFFFFC);
    wait_done("divu", c_DIV);

    issue(c_MTLO, 32'h12345678, 32'h0);
    check("mtlo_lo", E_LO, 32'h12345678);
    check("mtlo_hi_kept", E_HI, m_hi);
    check("mtlo_no_busy", 32'(E_Busy), 32'd0);
    m_lo = 32'h12345678;

    issue(c_DIVU, 32'h5, 32'h0);
    push(m_hi, m_lo);
    wait_done("div_by_zero", c_DIV);

    issue(c_DIVS, 32'h80000000, 32'hFFFFFFFF);
    push(32'h00000000, 32'h80000000);
    wait_done("div_ovf", c_DIV);

    issue(c_NONE, 32'hDEAD, 32'hBEEF);
    issue(c_RSVD, 32'hDEAD, 32'hBEEF);
    check("nop_busy", 32'(E_Busy), 32'd0);
    check("nop_hi", E_HI, m_hi);
    check("nop_lo", E_LO, m_lo);

    // MTHI pulsed mid-divide must be ignored
    issue(c_DIVS, 32'd100, 32'd7);
    push(32'd2, 32'd14);
    tick(); tick();
    E_Start = 1'b1; E_MDUOp = c_MTHI; E_MDUA = 32'hAAAA;
    #1;
    check("mthi_busy_stall", 32'(E_MDUStall), 32'd1);
    tick();
    E_Start = 1'b0; E_MDUOp = c_NONE;
    check("mthi_ignored", E_HI, m_hi);
    wait_done("div_after_mthi", c_DIV - 3);

    issue(c_MULTS, 32'd3, 32'd4);
    push(32'd0, 32'd12);
    wait_done("mult_back2back", c_MULT);

    issue(c_DIVS, 32'd50, 32'd3);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(E_Busy), 32'd0);
    check("midrst_hi", E_HI, 32'h0);
    check("midrst_lo", E_LO, 32'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("no_late_commit_hi", E_HI, 32'h0);
      check("no_late_commit_lo", E_LO, 32'h0);
      check("no_late_busy", 32'(E_Busy), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
